// File: rtl/uart_wb_bridge.sv
// UART command-packet to wishbone single-access bridge with status/read-data replies.
// Optional inter-byte gap resync enabled by defining UART_BRIDGE_RX_GAP_EN.
module uart_wb_bridge #(
  parameter int ADDR_BITS     = 32,
  parameter int BUS_TIMEOUT   = 256,
  parameter int RX_GAP_CYCLES = 1000000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [7:0]           tx_data,
  output logic                 tx_en,
  input  logic                 tx_ack,
  output logic                 wbm_cs_o,
  output logic [ADDR_BITS-3:0] wbm_addr_o,
  output logic [3:0]           wbm_sel_o,
  output logic [31:0]          wbm_data_o,
  output logic                 wbm_we_o,
  input  logic [31:0]          wbm_data_i,
  input  logic                 wbm_ack_i,
  output logic                 busy,
  output logic                 err
);

  localparam int TW = (BUS_TIMEOUT > 2) ? $clog2(BUS_TIMEOUT) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_BUS, S_RESP
  } state_e;

  state_e        state_q, state_d;
  logic          we_q, we_d;
  logic [3:0]    sel_q, sel_d;
  logic [1:0]    cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [31:0]   rdata_q, rdata_d;
  logic [7:0]    status_q, status_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [2:0]    idx_q, idx_d;
  logic          err_q, err_d;
  logic [2:0]    last_idx;

`ifdef UART_BRIDGE_RX_GAP_EN
  localparam int GW = (RX_GAP_CYCLES > 2) ? $clog2(RX_GAP_CYCLES) : 1;
  logic [GW-1:0] gap_q, gap_d;
`else
  localparam int unused_gap = RX_GAP_CYCLES;
`endif

  logic unused_addr;
  assign unused_addr = ^addr_q;

  // Only a successful read returns the four data bytes after status.
  assign last_idx = (status_q == 8'h00 && !we_q) ? 3'd4 : 3'd0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      sel_q    <= '0;
      cnt_q    <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      status_q <= '0;
      tmo_q    <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
`ifdef UART_BRIDGE_RX_GAP_EN
      gap_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      sel_q    <= sel_d;
      cnt_q    <= cnt_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
      status_q <= status_d;
      tmo_q    <= tmo_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
`ifdef UART_BRIDGE_RX_GAP_EN
      gap_q    <= gap_d;
`endif
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    sel_d    = sel_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    status_d = status_q;
    tmo_d    = tmo_q;
    idx_d    = idx_q;
    err_d    = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          we_d  = rx_data[7];
          sel_d = rx_data[3:0];
          cnt_d = '0;
          idx_d = '0;
          if (|rx_data[6:4]) begin
            status_d = 8'hCC;
            state_d  = S_RESP;
          end else begin
            state_d = S_ADDR;
          end
        end
      end
      S_ADDR: begin
        if (rx_valid) begin
          addr_d = {addr_q[23:0], rx_data};
          cnt_d  = cnt_q + 2'd1;
          tmo_d  = '0;
          if (cnt_q == 2'd3)
            state_d = we_q ? S_DATA : S_BUS;
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          wdata_d = {wdata_q[23:0], rx_data};
          cnt_d   = cnt_q + 2'd1;
          tmo_d   = '0;
          if (cnt_q == 2'd3)
            state_d = S_BUS;
        end
      end
      S_BUS: begin
        err_d = rx_valid;
        idx_d = '0;
        if (wbm_ack_i) begin
          if (!we_q)
            rdata_d = wbm_data_i;
          status_d = 8'h00;
          state_d  = S_RESP;
        end else if (tmo_q == TW'(BUS_TIMEOUT - 1)) begin
          status_d = 8'hEE;
          state_d  = S_RESP;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      S_RESP: begin
        err_d = rx_valid;
        if (tx_ack) begin
          if (idx_q == last_idx)
            state_d = S_IDLE;
          else
            idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
`ifdef UART_BRIDGE_RX_GAP_EN
    gap_d = '0;
    if (state_q == S_ADDR || state_q == S_DATA) begin
      if (rx_valid) begin
        gap_d = '0;
      end else if (gap_q == GW'(RX_GAP_CYCLES - 1)) begin
        state_d = S_IDLE;
        err_d   = 1'b1;
      end else begin
        gap_d = gap_q + 1'b1;
      end
    end
`endif
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    wbm_cs_o   = (state_q == S_BUS);
    tx_en      = (state_q == S_RESP);
    wbm_addr_o = addr_q[ADDR_BITS-1:2];
    wbm_sel_o  = sel_q;
    wbm_we_o   = we_q;
    wbm_data_o = wdata_q;
    err        = err_q;
    tx_data    = status_q;
    unique case (idx_q)
      3'd1:    tx_data = rdata_q[31:24];
      3'd2:    tx_data = rdata_q[23:16];
      3'd3:    tx_data = rdata_q[15:8];
      3'd4:    tx_data = rdata_q[7:0];
      default: tx_data = status_q;
    endcase
  end

endmodule

// File: tb/tb_uart_wb_bridge.sv
// Directed bench for uart_wb_bridge: write, read, timeout, bad cmd, reset, rx gap.
// Define UART_BRIDGE_RX_GAP_EN for both files to exercise the gap resync path.
module tb_uart_wb_bridge;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        tx_ack = 1'b0;
  logic        wbm_cs_o;
  logic [29:0] wbm_addr_o;
  logic [3:0]  wbm_sel_o;
  logic [31:0] wbm_data_o;
  logic        wbm_we_o;
  logic [31:0] wbm_data_i = 32'h1234_5678;
  logic        wbm_ack_i = 1'b0;
  logic        busy;
  logic        err;

  int n_cmp = 0;
  int n_bad = 0;

  int ack_dly = 0;
  int cyc = 0;
  int cs_len = 0;
  int cs_runs = 0;
  int err_cnt = 0;
  int unstable = 0;
  logic [29:0] addr_s;
  logic [3:0]  sel_s;
  logic        we_s;
  logic [31:0] dat_s;

  uart_wb_bridge #(
    .ADDR_BITS(32),
    .BUS_TIMEOUT(16),
    .RX_GAP_CYCLES(100)
  ) dut (
    .clk(clk), .rst(rst),
    .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_en(tx_en), .tx_ack(tx_ack),
    .wbm_cs_o(wbm_cs_o), .wbm_addr_o(wbm_addr_o),
    .wbm_sel_o(wbm_sel_o), .wbm_data_o(wbm_data_o),
    .wbm_we_o(wbm_we_o), .wbm_data_i(wbm_data_i),
    .wbm_ack_i(wbm_ack_i), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Slave model: acks in the ack_dly-th cycle of cs; ack_dly=0 never acks.
  always @(negedge clk) begin
    if (err) err_cnt = err_cnt + 1;
    if (wbm_cs_o) begin
      cyc = cyc + 1;
      if (cyc == 1) begin
        cs_runs = cs_runs + 1;
        addr_s = wbm_addr_o;
        sel_s  = wbm_sel_o;
        we_s   = wbm_we_o;
        dat_s  = wbm_data_o;
      end else if (addr_s != wbm_addr_o || sel_s != wbm_sel_o ||
                   we_s != wbm_we_o || dat_s != wbm_data_o) begin
        unstable = unstable + 1;
      end
      wbm_ack_i = (ack_dly != 0 && cyc == ack_dly);
    end else begin
      if (cyc != 0) cs_len = cyc;
      cyc = 0;
      wbm_ack_i = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_bad = n_bad + 1;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk) #1;
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk) #1;
    rx_valid = 1'b0;
  endtask

  task automatic recv(input string tag, input logic [7:0] exp,
                      input int hold);
    int k;
    k = 0;
    @(negedge clk);
    while (!tx_en && k < 200) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_en"}, {31'd0, tx_en}, 32'd1);
    chk(tag, {24'd0, tx_data}, {24'd0, exp});
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      chk({tag, "_hold"}, {23'd0, tx_en, tx_data}, {23'd0, 1'b1, exp});
    end
    @(posedge clk) #1;
    tx_ack = 1'b1;
    @(posedge clk) #1;
    tx_ack = 1'b0;
  endtask

  task automatic read_resp(input string tag);
    recv({tag, "_st"}, 8'h00, 2);
    recv({tag, "_b0"}, 8'h12, 2);
    recv({tag, "_b1"}, 8'h34, 0);
    recv({tag, "_b2"}, 8'h56, 0);
    recv({tag, "_b3"}, 8'h78, 0);
  endtask

  initial begin
    int e0, r0;
    #12;
    chk("rst_out", {28'd0, wbm_cs_o, tx_en, busy, err}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Write 0xDEADBEEF to byte address 8, ack in 3rd cycle.
    ack_dly = 3;
    send(8'h8F);
    send(8'h00); send(8'h00); send(8'h00);
    send(8'h08);
    send(8'hDE); send(8'hAD); send(8'hBE);
    chk("wr_precs", {31'd0, wbm_cs_o}, 32'd0);
    send(8'hEF);
    chk("wr_cs_rise", {31'd0, wbm_cs_o}, 32'd1);
    recv("wr_st", 8'h00, 0);
    chk("wr_addr", {2'd0, addr_s}, 32'd2);
    chk("wr_sel", {28'd0, sel_s}, 32'hF);
    chk("wr_we", {31'd0, we_s}, 32'd1);
    chk("wr_data", dat_s, 32'hDEADBEEF);
    chk("wr_cslen", cs_len, 32'd3);
    @(negedge clk);
    chk("wr_idle", {31'd0, busy}, 32'd0);

    // Read from byte address 4, ack in 1st cycle.
    ack_dly = 1;
    send(8'h0F);
    send(8'h00); send(8'h00); send(8'h00); send(8'h04);
    read_resp("rd");
    chk("rd_addr", {2'd0, addr_s}, 32'd1);
    chk("rd_we", {31'd0, we_s}, 32'd0);
    chk("rd_cslen", cs_len, 32'd1);
    @(negedge clk);
    chk("rd_idle", {31'd0, busy}, 32'd0);

    // Timeout, with a stray byte dropped during BUS.
    ack_dly = 0;
    e0 = err_cnt;
    send(8'h0F);
    send(8'h00); send(8'h00); send(8'h00); send(8'h10);
    send(8'h99);
    recv("to_st", 8'hEE, 0);
    chk("to_cslen", cs_len, 32'd16);
    chk("to_err", err_cnt - e0, 32'd1);
    @(negedge clk);
    chk("to_idle", {31'd0, busy}, 32'd0);

    // Bad command: no bus cycle, stray byte during RESP.
    r0 = cs_runs;
    e0 = err_cnt;
    send(8'h30);
    send(8'h55);
    repeat (2) @(negedge clk);
    chk("bad_err", err_cnt - e0, 32'd1);
    recv("bad_st", 8'hCC, 0);
    chk("bad_nobus", cs_runs - r0, 32'd0);
    @(negedge clk);
    chk("bad_idle", {31'd0, busy}, 32'd0);

    // Asynchronous reset mid-BUS.
    send(8'h0F);
    send(8'h00); send(8'h00); send(8'h00); send(8'h0C);
    repeat (3) @(negedge clk);
    #2 rst = 1'b1;
    #1 chk("arst", {29'd0, wbm_cs_o, tx_en, busy}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("arst_notx", {31'd0, tx_en}, 32'd0);
    ack_dly = 1;
    send(8'h0F);
    send(8'h00); send(8'h00); send(8'h00); send(8'h14);
    read_resp("rr");
    chk("rr_addr", {2'd0, addr_s}, 32'd5);

    // Inter-byte gap on a partial packet.
    e0 = err_cnt;
    send(8'h0F);
    send(8'h00); send(8'h00);
    repeat (110) @(negedge clk);
`ifdef UART_BRIDGE_RX_GAP_EN
    chk("gap_busy", {31'd0, busy}, 32'd0);
    chk("gap_err", err_cnt - e0, 32'd1);
    send(8'h0F);
    send(8'h00); send(8'h00); send(8'h00); send(8'h20);
`else
    chk("gap_busy", {31'd0, busy}, 32'd1);
    chk("gap_err", err_cnt - e0, 32'd0);
    send(8'h00); send(8'h20);
`endif
    read_resp("gp");
    chk("gp_addr", {2'd0, addr_s}, 32'd8);
    chk("cs_stable", unstable, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/uart_wb_bridge.md
Name: uart_wb_bridge

Overview:
- Debug bus initiator: parses command packets from a UART byte stream and issues single wishbone master read/write transactions.
- Returns status and read data as a response byte stream.
- Sits between the uart_core_rx/uart_core_tx pair and the peripheral bus, so a host PC can access any wishbone device (e.g. wb_uart registers) over the serial line.

Parameters:
- ADDR_BITS, 32, wishbone byte-address width; the bus carries [ADDR_BITS-1:2].
- BUS_TIMEOUT, 256, cycles to wait for wbm_ack_i before aborting; must be ≥2.
- RX_GAP_CYCLES, 1000000, inter-byte gap limit; used only with the optional feature.

Ports:
- clk  in  1  bridge and wishbone clock
- rst  in  1  asynchronous active-high reset
- rx_data  in  8  received byte from uart_core_rx
- rx_valid  in  1  one-cycle pulse; rx_data valid
- tx_data  out  8  response byte to uart_core_tx
- tx_en  out  1  response byte pending; held until consumed
- tx_ack  in  1  one-cycle pulse; tx_data consumed
- wbm_cs_o  out  1  wishbone cycle/strobe
- wbm_addr_o  out  ADDR_BITS-2  word address [ADDR_BITS-1:2]
- wbm_sel_o  out  4  byte selects
- wbm_data_o  out  32  write data
- wbm_we_o  out  1  write enable
- wbm_data_i  in  32  read data
- wbm_ack_i  in  1  slave acknowledge
- busy  out  1  high whenever state is not IDLE
- err  out  1  one-cycle pulse on a dropped byte or aborted packet

Behaviour:
- Reset is asynchronous. All outputs, registers and counters go to 0. State goes to IDLE.
- Packet format:
  - Byte 0 is CMD: bit7 = we, bits6:4 must be 000, bits3:0 = sel.
  - Bytes 1-4 are the address, MSB first.
  - Bytes 5-8 are the write data, MSB first, and are present only when we=1.
  - Address bits [1:0] are ignored.
- States: IDLE, ADDR, DATA, BUS, RESP.
- IDLE:
  - On rx_valid, latch CMD.
  - If bits6:4 are nonzero, load status 0xCC and go to RESP.
  - Otherwise go to ADDR with the byte counter at 0.
- ADDR: each rx_valid shifts one byte into the address. After the 4th byte, go to DATA if we=1, else go to BUS.
- DATA: same as ADDR, shifting into the write data. After the 4th byte, go to BUS.
- BUS:
  - wbm_cs_o rises on the clock edge that enters BUS, i.e. 1 cycle after the last byte's rx_valid.
  - addr, sel, data and we are stable for the whole time cs is high.
  - On an edge where wbm_ack_i=1: cs<=0, capture wbm_data_i (reads), status=0x00, go to RESP.
  - The timeout counter starts at 0 on the edge that asserts cs. If the count reaches BUS_TIMEOUT-1 with no ack, set cs<=0 and status=0xEE, and go to RESP.
  - An ack that arrives on the timeout edge wins.
  - cs is never high for 2 cycles after an ack is sampled.
- RESP:
  - Byte sequence is the status byte, then 4 read-data bytes MSB first, sent only for a successful read.
  - Writes, timeouts and bad commands send the status byte only.
  - tx_en=1 with tx_data valid. Each tx_ack advances to the next byte.
  - tx_ack on the last byte drops tx_en on the same edge and returns to IDLE.
  - tx_ack while tx_en=0 is ignored.
- rx_valid in BUS or RESP: the byte is dropped and err pulses for 1 cycle. The packet in flight is unaffected.
- Reset during BUS drops cs immediately (asynchronously). No response is sent.
- Address and data byte counters are 2 bits; no wrap beyond 4 bytes is possible, because the state changes on the 4th byte.

Optional Feature:
- Macro: UART_BRIDGE_RX_GAP_EN.
- When defined:
  - In ADDR or DATA, a counter clears on every rx_valid and increments otherwise.
  - When it reaches RX_GAP_CYCLES-1, the partial packet is discarded, err pulses for 1 cycle, and the state returns to IDLE. No response is sent.
  - This resynchronises the parser after a host-side glitch.
- When undefined: no gap counter exists, RX_GAP_CYCLES is unused, and the parser waits indefinitely for the remaining bytes.

Test Plan:
- Write: rx bytes 0x8F, 0x00,0x00,0x00,0x08, 0xDE,0xAD,0xBE,0xEF; slave acks after 3 cycles → addr=2, sel=F, we=1, data=0xDEADBEEF; cs high exactly 3 cycles; response byte 0x00.
- Read: rx 0x0F, 0x00,0x00,0x00,0x04; slave returns 0x12345678 with ack after 1 cycle → response bytes 0x00,0x12,0x34,0x56,0x78, each held until tx_ack.
- Timeout: read with wbm_ack_i tied 0 → cs high exactly BUS_TIMEOUT cycles then 0; response 0xEE only; busy=0 after its tx_ack.
- Bad command 0x30 → no bus cycle; response 0xCC. Extra rx byte sent during RESP → err pulse; response unchanged.
- Reset asserted mid-BUS → cs, tx_en and busy go to 0 without a clock edge; a next read packet completes normally.
- With UART_BRIDGE_RX_GAP_EN and RX_GAP_CYCLES=100: send CMD plus 2 address bytes, then idle 100 cycles → err pulse, IDLE; a following full packet executes correctly. Without the macro the same stimulus stays in ADDR.
